alu_flag_stage: RTL and testbench

Registered result/flag stage directly downstream of the ALU subtractor. Accepts the subtractor's result and N, V, Co flags through a valid/ready handshake, derives the zero flag, and presents a registered result/flag bundle to the next consumer, such as a writeback or compare unit. A two-entry skid buffer gives full throughput with a registered `in_ready`. Optional sticky overflow/carry flags accumulate across consumed results.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_skid_buffer.sv | 75 +++++++
 rtl/alu_flag_stage.sv | 82 ++++++++
 tb/tb_alu_flag_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default result width, flag bundle and skid-buffer state encoding.
package alu_pkg;

    localparam int ALU_BITS = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;

    localparam int ALU_FLAGS_W = $bits(alu_flags_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry skid buffer: main register drives the outputs, skid register absorbs one bundle of back-pressure.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_e       state_p0, state_nxt;
    logic [DATA_W-1:0] main_p0, main_nxt;
    logic [DATA_W-1:0] skid_p0, skid_nxt;
    logic              in_xfer, out_xfer;

    // Both handshake outputs come straight from the state register, so
    // neither depends combinationally on in_valid or out_ready.
    assign in_ready  = (state_p0 != TWO);
    assign out_valid = (state_p0 != EMPTY);
    assign out_data  = main_p0;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_nxt = state_p0;
        main_nxt  = main_p0;
        skid_nxt  = skid_p0;
        unique case (state_p0)
            EMPTY: begin
                if (in_xfer) begin
                    main_nxt  = in_data;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_nxt = in_data;
                end else if (in_xfer) begin
                    skid_nxt  = in_data;
                    state_nxt = TWO;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    main_nxt  = skid_p0;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Storage stage: reset discards anything held, including an in-flight bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= EMPTY;
            main_p0  <= '0;
            skid_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            main_p0  <= main_nxt;
            skid_p0  <= skid_nxt;
        end
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage after the ALU subtractor; derives Z and buffers via alu_skid_buffer.
// Optional sticky V/C accumulation is enabled by defining ALU_STICKY_FLAGS_EN.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int bits = ALU_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [bits-1:0] in_result,
    input  logic                   in_n,
    input  logic                   in_v,
    input  logic                   in_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [bits-1:0] out_result,
    output logic                   out_n,
    output logic                   out_z,
    output logic                   out_v,
    output logic                   out_c
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic                   sticky_clr,
    output logic                   sticky_v,
    output logic                   sticky_c
`endif
);

    localparam int PAYLOAD_W = bits + ALU_FLAGS_W;

    alu_flags_t             in_flags, out_flags;
    logic [PAYLOAD_W-1:0]   in_payload, out_payload;

    // C keeps the subtractor's Co polarity; no borrow inversion here.
    always_comb begin
        in_flags.n = in_n;
        in_flags.z = (in_result == '0);
        in_flags.v = in_v;
        in_flags.c = in_co;
    end

    assign in_payload = {in_result, in_flags};

    alu_skid_buffer #(
        .DATA_W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign out_result = out_payload[PAYLOAD_W-1:ALU_FLAGS_W];
    assign out_flags  = out_payload[ALU_FLAGS_W-1:0];
    assign out_n      = out_flags.n;
    assign out_z      = out_flags.z;
    assign out_v      = out_flags.v;
    assign out_c      = out_flags.c;

`ifdef ALU_STICKY_FLAGS_EN
    logic out_xfer;
    assign out_xfer = out_valid & out_ready;

    // Sticky stage: a flag set by this cycle's consumed bundle overrides a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_v <= 1'b0;
            sticky_c <= 1'b0;
        end else begin
            sticky_v <= (sticky_clr ? 1'b0 : sticky_v) | (out_xfer & out_flags.v);
            sticky_c <= (sticky_clr ? 1'b0 : sticky_c) | (out_xfer & out_flags.c);
        end
    end
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: expected bundles queued on acceptance, compared while presented.
`timescale 1ns/1ps
module tb_alu_flag_stage;

    localparam int BITS = 4;

    typedef struct packed {
        logic [BITS-1:0] r;
        logic            n;
        logic            z;
        logic            v;
        logic            c;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_result = '0;
    logic            in_n = 1'b0;
    logic            in_v = 1'b0;
    logic            in_co = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] out_result;
    logic            out_n, out_z, out_v, out_c;
`ifdef ALU_STICKY_FLAGS_EN
    logic            sticky_clr = 1'b0;
    logic            sticky_v, sticky_c;
`endif

    exp_t q[$];
    int   occ = 0;
    logic m_sv = 1'b0;
    logic m_sc = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_flag_stage #(.bits(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_n      (in_n),
        .in_v      (in_v),
        .in_co     (in_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_n     (out_n),
        .out_z     (out_z),
        .out_v     (out_v),
        .out_c     (out_c)
`ifdef ALU_STICKY_FLAGS_EN
        ,
        .sticky_clr(sticky_clr),
        .sticky_v  (sticky_v),
        .sticky_c  (sticky_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check what is presented now, update the model, advance to the next falling edge.
    task automatic cycle(output bit acc);
        bit   ix, ox;
        exp_t e;
        #1;
        ix = in_valid & in_ready;
        ox = out_valid & out_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, occ < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, occ > 0});
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                e = q[0];
                chk("out_result", {28'd0, out_result}, {28'd0, e.r});
                chk("out_flags", {28'd0, out_n, out_z, out_v, out_c}, {28'd0, e.n, e.z, e.v, e.c});
            end
        end
`ifdef ALU_STICKY_FLAGS_EN
        chk("sticky_v", {31'd0, sticky_v}, {31'd0, m_sv});
        chk("sticky_c", {31'd0, sticky_c}, {31'd0, m_sc});
        e = (q.size() > 0) ? q[0] : '0;
        m_sv = (sticky_clr ? 1'b0 : m_sv) | (ox & e.v);
        m_sc = (sticky_clr ? 1'b0 : m_sc) | (ox & e.c);
`endif
        if (ox && q.size() > 0) void'(q.pop_front());
        if (ix) begin
            e.r = in_result;
            e.n = in_n;
            e.z = (in_result == 4'd0);
            e.v = in_v;
            e.c = in_co;
            q.push_back(e);
        end
        if (ix && occ < 2) occ++;
        if (ox && occ > 0) occ--;
        @(posedge clk);
        @(negedge clk);
        acc = ix;
    endtask

    task automatic send(input logic [BITS-1:0] r, input logic n, input logic v, input logic co);
        bit acc;
        int k;
        in_valid  = 1'b1;
        in_result = r;
        in_n      = n;
        in_v      = v;
        in_co     = co;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            cycle(acc);
            k++;
        end
        if (!acc) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    initial begin
        bit acc;
        int got;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outputs", {27'd0, out_result, out_n, out_z, out_v, out_c}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Zero flag
        out_ready = 1'b1;
        send(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("zero_out_z", {31'd0, out_z}, 32'd1);
        chk("zero_out_c", {31'd0, out_c}, 32'd1);
        chk("zero_out_result", {28'd0, out_result}, 32'd0);
        send(4'b1110, 1'b1, 1'b0, 1'b0);
        chk("nz_out_z", {31'd0, out_z}, 32'd0);
        chk("nz_out_n", {31'd0, out_n}, 32'd1);
        idle(2);

        // Back-pressure: 1 in main, 2 in skid, 3 held upstream
        out_ready = 1'b0;
        send(4'd1, 1'b0, 1'b0, 1'b1);
        send(4'd2, 1'b0, 1'b1, 1'b0);
        in_result = 4'd3;
        in_n = 1'b0; in_v = 1'b0; in_co = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(acc);
            chk("held_not_accepted", {31'd0, acc}, 32'd0);
        end
        out_ready = 1'b1;
        send(4'd3, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("bp_drained", q.size(), 32'd0);

        // Full throughput
        got = 0;
        for (int i = 0; i < 16; i++) begin
            send(4'(i * 5 + 1), i[0], i[1], i[2]);
            got++;
        end
        chk("tput_accepts", got, 32'd16);
        idle(2);
        chk("tput_drained", q.size(), 32'd0);

        // Stall stability with random payloads
        out_ready = 1'b0;
        send(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(5);
        out_ready = 1'b1;
        idle(2);

`ifdef ALU_STICKY_FLAGS_EN
        send(4'd7, 1'b0, 1'b1, 1'b0);
        send(4'd6, 1'b0, 1'b0, 1'b0);
        send(4'd5, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("sticky_v_held", {31'd0, sticky_v}, 32'd1);
        sticky_clr = 1'b1;
        idle(1);
        sticky_clr = 1'b0;
        chk("sticky_v_cleared", {31'd0, sticky_v}, 32'd0);
        send(4'd9, 1'b1, 1'b1, 1'b1);
        sticky_clr = 1'b1;
        idle(1);
        sticky_clr = 1'b0;
        chk("sticky_set_wins_v", {31'd0, sticky_v}, 32'd1);
        chk("sticky_set_wins_c", {31'd0, sticky_c}, 32'd1);
        idle(1);
`endif

        // Reset mid-stream while holding TWO
        out_ready = 1'b0;
        send(4'd10, 1'b1, 1'b1, 1'b1);
        send(4'd11, 1'b1, 1'b0, 1'b1);
        in_valid  = 1'b1;
        in_result = 4'd12;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_outputs", {27'd0, out_result, out_n, out_z, out_v, out_c}, 32'd0);
`ifdef ALU_STICKY_FLAGS_EN
        chk("mid_rst_sticky", {30'd0, sticky_v, sticky_c}, 32'd0);
`endif
        in_valid = 1'b0;
        q.delete();
        occ  = 0;
        m_sv = 1'b0;
        m_sc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(4'd4, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("post_rst_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
